// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers and FSM state type shared by the AES MixColumns engine.
package aes_gf_pkg;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x (i.e. by 2) in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by x+1 (i.e. by 3) in GF(2^8).
  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

endpackage

// File: rtl/aes_mixcol_word.sv
// Combinational forward MixColumns of one 32-bit column (row 0 in the MSB byte).
module aes_mixcol_word
  import aes_gf_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign col_out = {xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
                    a0 ^ xtime(a1) ^ gf_mul3(a2) ^ a3,
                    a0 ^ a1 ^ xtime(a2) ^ gf_mul3(a3),
                    gf_mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};

endmodule

// File: rtl/aes_mixcolumns_seq.sv
// Sequential AES MixColumns engine: one state per handshake, LANES columns per clock,
// result held until accepted, optional per-block bypass for the final round.
module aes_mixcolumns_seq
  import aes_gf_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_skip,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int BEATS = 4 / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("aes_mixcolumns_seq: LANES must be 1, 2 or 4");
  end

  state_t           state, state_next;
  logic [CNT_W-1:0] beat;
  logic [127:0]     work, work_mixed;
  int               col_base;
  logic [31:0]      lane_in  [LANES];
  logic [31:0]      lane_out [LANES];

  // With a single beat every lane maps to a fixed column, so keep the index constant.
  assign col_base = (BEATS > 1) ? int'(beat) * LANES : 0;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_in[gi] = work[127 - 32 * (col_base + gi) -: 32];

    aes_mixcol_word u_word (
      .col_in  (lane_in[gi]),
      .col_out (lane_out[gi])
    );
  end

  // Working register with the current beat's columns replaced by their mixed values.
  always_comb begin
    work_mixed = work;
    for (int i = 0; i < LANES; i++) begin
      work_mixed[127 - 32 * (col_base + i) -: 32] = lane_out[i];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = in_skip ? DONE : BUSY;
      BUSY:    if (beat == LAST_BEAT) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the incoming state, then mix one group of columns per beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
      work <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            beat <= '0;
          end
        end
        BUSY: begin
          work <= work_mixed;
          if (beat != LAST_BEAT) beat <= beat + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs depend on state alone; data is zero unless a result is presented.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    out_data  = (state == DONE) ? work : '0;
  end

endmodule

// File: tb/tb_aes_mixcolumns_seq.sv
// Directed and randomised bench for aes_mixcolumns_seq at LANES = 1, 2 and 4.
module tb_aes_mixcolumns_seq;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] FIX_IN   = 128'h01010101c6c6c6c6d4d4d4d52d26314c;
  localparam logic [127:0] FIX_OUT  = 128'h01010101c6c6c6c6d5d5d7d64d7ebdf8;
  localparam logic [127:0] SKP_IN   = 128'hdb135345f20a225c0101010100000000;
  localparam logic [127:0] SKP_OUT  = 128'h8e4da1bc9fdc589d0101010100000000;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   in_valid, in_ready, in_skip, out_valid, out_ready;
  logic [127:0] in_data  [3];
  logic [127:0] out_data [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    aes_mixcolumns_seq #(.LANES(1 << gi)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_data   (in_data[gi]),
      .in_skip   (in_skip[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .out_data  (out_data[gi])
    );
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Reference GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic       hi;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = x << 1;
      if (hi) x = x ^ 8'h1b;
      y  = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    logic [127:0] r;
    logic [31:0]  w;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      w  = s[127 - 32 * c -: 32];
      a0 = w[31:24]; a1 = w[23:16]; a2 = w[15:8]; a3 = w[7:0];
      r[127 - 32 * c -: 32] = {gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3,
                               a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3,
                               a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3),
                               gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2)};
    end
    return r;
  endfunction

  // One full transaction on instance k; hold = clocks of out_ready=0 while DONE.
  task automatic run_block(input int k, input logic [127:0] d, input logic sk,
                           input logic [127:0] exp, input int exp_lat, input int hold,
                           input bit rnd_ready, output time hs_time);
    int   cyc;
    logic busy_ok, hold_ok;
    @(negedge clk);
    check_val("in_ready_idle", in_ready[k], 1'b1);
    in_valid[k]  = 1'b1;
    in_data[k]   = d;
    in_skip[k]   = sk;
    out_ready[k] = 1'b0;
    @(posedge clk);
    hs_time = $time;
    #1;
    in_valid[k] = 1'b0;
    in_data[k]  = ~d;
    in_skip[k]  = ~sk;
    cyc = 0;
    busy_ok = 1'b1;
    while (!out_valid[k] && cyc < 20) begin
      if (in_ready[k]) busy_ok = 1'b0;
      if (rnd_ready) out_ready[k] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    check_val("latency", 128'(cyc + 1), 128'(exp_lat));
    check_val("in_ready_busy", busy_ok, 1'b1);
    check_val("out_data", out_data[k], exp);
    out_ready[k] = (hold == 0);
    hold_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      in_valid[k] = 1'b1;
      in_data[k]  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      if (out_valid[k] !== 1'b1 || out_data[k] !== exp || in_ready[k] !== 1'b0) hold_ok = 1'b0;
    end
    if (hold > 0) begin
      check_val("hold_stable", hold_ok, 1'b1);
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end
    @(posedge clk); #1;
    check_val("release_ready", in_ready[k], 1'b1);
    check_val("release_valid", out_valid[k], 1'b0);
    out_ready[k] = 1'b0;
    $display("blk lanes=%0d skip=%0d in=%h out=%h lat=%0d hold=%0d", 1 << k, sk, d, exp, cyc + 1, hold);
  endtask

  initial begin
    time t, t_prev;
    logic [127:0] d;
    logic sk;
    int k, hold;

    rst       = 1'b1;
    in_valid  = '0;
    in_skip   = '0;
    out_ready = '0;
    for (int i = 0; i < 3; i++) in_data[i] = '0;

    #2;
    for (int i = 0; i < 3; i++) begin
      check_val("rst_in_ready", in_ready[i], 1'b1);
      check_val("rst_out_valid", out_valid[i], 1'b0);
      check_val("rst_out_data", out_data[i], '0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    run_block(0, FIPS_IN, 1'b0, FIPS_OUT, 5, 0, 1'b0, t);
    run_block(1, FIPS_IN, 1'b0, FIPS_OUT, 3, 0, 1'b0, t);
    run_block(2, FIX_IN,  1'b0, FIX_OUT,  2, 0, 1'b0, t);
    run_block(0, FIX_IN,  1'b0, FIX_OUT,  5, 0, 1'b0, t);
    run_block(0, SKP_IN,  1'b1, SKP_IN,   1, 0, 1'b0, t);
    run_block(2, SKP_IN,  1'b1, SKP_IN,   1, 0, 1'b0, t);
    run_block(1, SKP_IN,  1'b0, SKP_OUT,  3, 0, 1'b0, t);
    run_block(2, SKP_IN,  1'b0, SKP_OUT,  2, 0, 1'b0, t);

    // Backpressure for 10 clocks with in_valid pulses that must be ignored.
    run_block(0, FIPS_IN, 1'b0, FIPS_OUT, 5, 10, 1'b0, t);
    run_block(2, FIX_IN,  1'b0, FIX_OUT,  2, 10, 1'b0, t);

    // Reset in the middle of a LANES=1 block, after beats 0 and 1 have run.
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = FIPS_IN; in_skip[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_val("midrst_in_ready", in_ready[0], 1'b1);
    check_val("midrst_out_valid", out_valid[0], 1'b0);
    check_val("midrst_out_data", out_data[0], '0);
    @(negedge clk);
    rst = 1'b0;
    run_block(0, FIPS_IN, 1'b0, FIPS_OUT, 5, 0, 1'b0, t);

    // Reset while a result is being presented must clear it immediately.
    @(negedge clk);
    in_valid[1] = 1'b1; in_data[1] = SKP_IN; in_skip[1] = 1'b1; out_ready[1] = 1'b0;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    check_val("done_out_data", out_data[1], SKP_IN);
    #2;
    rst = 1'b1;
    #1;
    check_val("donerst_out_valid", out_valid[1], 1'b0);
    check_val("donerst_out_data", out_data[1], '0);
    check_val("donerst_in_ready", in_ready[1], 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Throughput: BEATS+2 clocks between handshakes with out_ready held high.
    for (int i = 0; i < 3; i++) begin
      t_prev = 0;
      for (int j = 0; j < 4; j++) begin
        run_block(i, FIX_IN, 1'b0, FIX_OUT, (4 >> i) + 1, 0, 1'b0, t);
        if (j > 0) check_val("throughput", 128'((t - t_prev) / 10), 128'((4 >> i) + 2));
        t_prev = t;
      end
    end

    // Random blocks against the reference model with random out_ready.
    for (int it = 0; it < 1000; it++) begin
      k    = it % 3;
      d    = {$urandom, $urandom, $urandom, $urandom};
      sk   = ($urandom_range(0, 7) == 0);
      hold = $urandom_range(0, 3);
      run_block(k, d, sk, sk ? d : mix_model(d), sk ? 1 : (4 >> k) + 1, hold, 1'b1, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
